// File: rtl/neuron_backprop.sv
// Backward ReLU-derivative gate: derives per-channel masks from forward pre-activations,
// queues them in order, and gates backward error words. Optional flush: NEURON_BACKPROP_FLUSH_EN.
module neuron_backprop #(
    parameter  int NP    = 4,
    parameter  int NC    = 4,
    parameter  int WD    = 4,
    parameter  int DEPTH = 4,
    localparam int VW    = $clog2(NP) + 1 + WD,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             iCLK,
    input  logic             iRST,
`ifdef NEURON_BACKPROP_FLUSH_EN
    input  logic             iFlush,
`endif
    input  logic             iValid_AF,
    output logic             oReady_AF,
    input  logic [NC*VW-1:0] iData_AF,
    input  logic             iValid_BD,
    output logic             oReady_BD,
    input  logic [NC*WD-1:0] iData_BD,
    output logic             oValid_AD,
    input  logic             iReady_AD,
    output logic [NC*WD-1:0] oData_AD,
    output logic [CW-1:0]    oCount
);

    localparam int AW = $clog2(DEPTH);
    localparam logic signed [VW-1:0] MAX_YC = VW'((2 ** (WD - 1)) - 1);
    localparam logic signed [VW-1:0] V_ZERO = '0;

    logic [NC-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic [NC*WD-1:0] data_q, data_d;

    logic             flush;
    logic             w_rdy;
    logic             push;
    logic             pop;
    logic [NC-1:0]    mask_w;
    logic [NC-1:0]    rd_mask;
    logic signed [VW-1:0] v_c;

`ifdef NEURON_BACKPROP_FLUSH_EN
    assign flush = iFlush;
`else
    assign flush = 1'b0;
`endif

    // Readies depend only on registered state (and flush), never on the same-cycle pop.
    assign w_rdy     = !valid_q || iReady_AD;
    assign oReady_AF = (count_q < CW'(DEPTH)) && !flush;
    assign oReady_BD = (count_q != '0) && w_rdy && !flush;
    assign push      = iValid_AF && oReady_AF;
    assign pop       = iValid_BD && oReady_BD;

    assign oValid_AD = valid_q;
    assign oData_AD  = data_q;
    assign oCount    = count_q;
    assign rd_mask   = mem_q[rptr_q];

    // ReLU derivative, also zero where the forward stage saturated.
    always_comb begin
        mask_w = '0;
        v_c    = '0;
        for (int unsigned c = 0; c < NC; c++) begin
            v_c       = iData_AF[c*VW +: VW];
            mask_w[c] = (v_c > V_ZERO) && (v_c <= MAX_YC);
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        valid_d = valid_q;
        data_d  = data_q;

        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end

        if (pop) begin
            valid_d = 1'b1;
            for (int unsigned c = 0; c < NC; c++) begin
                data_d[c*WD +: WD] = rd_mask[c] ? iData_BD[c*WD +: WD] : '0;
            end
        end else if (valid_q && iReady_AD) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (push) mem_q[wptr_q] <= mask_w;
    end

endmodule

// File: tb/tb_neuron_backprop.sv
// Bench for neuron_backprop: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_neuron_backprop;

    localparam int NP    = 4;
    localparam int NC    = 4;
    localparam int WD    = 4;
    localparam int DEPTH = 4;
    localparam int VW    = $clog2(NP) + 1 + WD;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             iCLK = 1'b0;
    logic             iRST;
    logic             iFlush;
    logic             iValid_AF;
    logic             oReady_AF;
    logic [NC*VW-1:0] iData_AF;
    logic             iValid_BD;
    logic             oReady_BD;
    logic [NC*WD-1:0] iData_BD;
    logic             oValid_AD;
    logic             iReady_AD;
    logic [NC*WD-1:0] oData_AD;
    logic [CW-1:0]    oCount;

    int n_cmp = 0;
    int n_err = 0;

    always #5 iCLK = ~iCLK;

    neuron_backprop #(.NP(NP), .NC(NC), .WD(WD), .DEPTH(DEPTH)) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
`ifdef NEURON_BACKPROP_FLUSH_EN
        .iFlush    (iFlush),
`endif
        .iValid_AF (iValid_AF),
        .oReady_AF (oReady_AF),
        .iData_AF  (iData_AF),
        .iValid_BD (iValid_BD),
        .oReady_BD (oReady_BD),
        .iData_BD  (iData_BD),
        .oValid_AD (oValid_AD),
        .iReady_AD (iReady_AD),
        .oData_AD  (oData_AD),
        .oCount    (oCount)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [NC-1:0] mask_of(input logic [NC*VW-1:0] d);
        logic [NC-1:0]        m;
        logic signed [VW-1:0] s;
        int                   v;
        m = '0;
        for (int c = 0; c < NC; c++) begin
            s    = d[c*VW +: VW];
            v    = s;
            m[c] = (v >= 1) && (v <= (2 ** (WD - 1)) - 1);
        end
        return m;
    endfunction

    function automatic logic [NC*WD-1:0] gate(input logic [NC-1:0] m, input logic [NC*WD-1:0] e);
        logic [NC*WD-1:0] o;
        o = '0;
        for (int c = 0; c < NC; c++)
            if (m[c]) o[c*WD +: WD] = e[c*WD +: WD];
        return o;
    endfunction

    logic [NC-1:0]    mq[$];
    logic             m_valid;
    logic [NC*WD-1:0] m_data;

    function automatic logic m_rdy_af();
        return (mq.size() < DEPTH) && !iFlush;
    endfunction

    function automatic logic m_rdy_bd();
        return (mq.size() != 0) && (!m_valid || iReady_AD) && !iFlush;
    endfunction

    always @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            mq.delete();
            m_valid = 1'b0;
            m_data  = '0;
        end else begin
            logic do_push, do_pop;
            logic [NC-1:0] m;
            do_push = iValid_AF && m_rdy_af();
            do_pop  = iValid_BD && m_rdy_bd();
            if (iFlush) mq.delete();
            if (do_pop) begin
                m       = mq.pop_front();
                m_data  = gate(m, iData_BD);
                m_valid = 1'b1;
            end else if (m_valid && iReady_AD) begin
                m_valid = 1'b0;
            end
            if (do_push) mq.push_back(mask_of(iData_AF));
        end
    end

    always @(negedge iCLK) begin
        if (iRST) begin
            chk("count",  64'(oCount),    64'(mq.size()));
            chk("rdy_af", 64'(oReady_AF), 64'(m_rdy_af()));
            chk("rdy_bd", 64'(oReady_BD), 64'(m_rdy_bd()));
            chk("valid",  64'(oValid_AD), 64'(m_valid));
            chk("data",   64'(oData_AD),  64'(m_data));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [NC*VW-1:0] rand_v();
        logic [NC*VW-1:0] d;
        for (int c = 0; c < NC; c++)
            d[c*VW +: VW] = VW'($urandom_range(0, 20)) - VW'(10);
        return d;
    endfunction

    logic [NC*WD-1:0] held;

    initial begin
        iRST = 1'b0; iFlush = 1'b0;
        iValid_AF = 1'b0; iData_AF = '0;
        iValid_BD = 1'b0; iData_BD = '0;
        iReady_AD = 1'b1;
        step(); step();
        iRST = 1'b1;
        step();
        chk("rst_count", 64'(oCount),    64'd0);
        chk("rst_valid", 64'(oValid_AD), 64'd0);
        chk("rst_data",  64'(oData_AD),  64'd0);
        chk("rst_rdyaf", 64'(oReady_AF), 64'd1);

        // mask derivation: ch3..ch0 v = 9,5,0,-3 ; err = -8,3,-1,2
        iValid_AF = 1'b1; iData_AF = {7'sd9, 7'sd5, 7'sd0, -7'sd3};
        step();
        iValid_AF = 1'b0;
        iValid_BD = 1'b1; iData_BD = 16'h83F2;
        step();
        iValid_BD = 1'b0;
        chk("mask_valid", 64'(oValid_AD), 64'd1);
        chk("mask_data",  64'(oData_AD),  64'h0300);
        step();

        // 7 passes, 8 and -64 blocked; all-pass mask lets -8 through unchanged
        iValid_AF = 1'b1; iData_AF = {7'sd8, 7'sd7, 7'sd1, -7'sd64};
        step();
        iData_AF = {7'sd1, 7'sd2, 7'sd3, 7'sd4};
        step();
        iValid_AF = 1'b0;
        iValid_BD = 1'b1; iData_BD = 16'h8888;
        step();
        chk("sat_data", 64'(oData_AD), 64'h0880);
        step();
        iValid_BD = 1'b0;
        chk("neg_pass", 64'(oData_AD), 64'h8888);
        step();

        // full boundary
        iValid_AF = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            iData_AF = rand_v();
            step();
        end
        chk("full_rdy",   64'(oReady_AF), 64'd0);
        chk("full_count", 64'(oCount),    64'd4);
        iValid_BD = 1'b1; iData_BD = 16'h1234;
        step();
        chk("full_pop",  64'(oCount),    64'd3);
        chk("full_pval", 64'(oValid_AD), 64'd1);
        iValid_BD = 1'b0;
        chk("full_rdy2", 64'(oReady_AF), 64'd1);
        step();
        chk("full_push", 64'(oCount), 64'd4);
        iValid_AF = 1'b0; iValid_BD = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            iData_BD = 16'($urandom);
            step();
        end
        chk("drained", 64'(oCount), 64'd0);

        // empty boundary: backward valid held with nothing queued
        for (int i = 0; i < 3; i++) begin
            step();
            chk("empty_rdy", 64'(oReady_BD), 64'd0);
            chk("empty_val", 64'(oValid_AD), 64'd0);
        end
        iValid_AF = 1'b1; iData_AF = {7'sd1, 7'sd1, 7'sd1, 7'sd1};
        step();
        iValid_AF = 1'b0;
        chk("empty_push_val", 64'(oValid_AD), 64'd0);
        chk("empty_push_rdy", 64'(oReady_BD), 64'd1);
        iData_BD = 16'h5A5A;
        step();
        iValid_BD = 1'b0;
        chk("empty_out", 64'(oData_AD), 64'h5A5A);
        step();

        // backpressure
        iValid_AF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iData_AF = rand_v();
            step();
        end
        iValid_AF = 1'b0;
        iReady_AD = 1'b0; iValid_BD = 1'b1; iData_BD = 16'hFFFF;
        step();
        held = oData_AD;
        for (int i = 0; i < 5; i++) begin
            iData_BD = 16'($urandom);
            step();
            chk("bp_data",  64'(oData_AD),  64'(held));
            chk("bp_rdy",   64'(oReady_BD), 64'd0);
            chk("bp_count", 64'(oCount),    64'd2);
        end
        iReady_AD = 1'b1;
        step();
        chk("bp_pop1", 64'(oCount), 64'd1);
        step();
        chk("bp_pop2", 64'(oCount), 64'd0);
        iValid_BD = 1'b0;
        step();

        // asynchronous reset mid-stream
        iValid_AF = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iData_AF = rand_v();
            step();
        end
        iValid_AF = 1'b0;
        iReady_AD = 1'b0; iValid_BD = 1'b1; iData_BD = 16'h7777;
        step();
        iValid_BD = 1'b0;
        chk("pre_rst_count", 64'(oCount),    64'd3);
        chk("pre_rst_valid", 64'(oValid_AD), 64'd1);
        #2;
        iRST = 1'b0;
        #1;
        chk("arst_count", 64'(oCount),    64'd0);
        chk("arst_valid", 64'(oValid_AD), 64'd0);
        chk("arst_data",  64'(oData_AD),  64'd0);
        step();
        iRST = 1'b1; iReady_AD = 1'b1;
        step();

        // random traffic, checked by the model every cycle
        for (int i = 0; i < 300; i++) begin
            iValid_AF = 1'($urandom_range(0, 2) != 0);
            iData_AF  = rand_v();
            iValid_BD = 1'($urandom_range(0, 2) != 0);
            iData_BD  = 16'($urandom);
            iReady_AD = 1'($urandom_range(0, 3) != 0);
            step();
        end
        iValid_AF = 1'b0; iValid_BD = 1'b0; iReady_AD = 1'b1;
        step(); step();

`ifdef NEURON_BACKPROP_FLUSH_EN
        // drain anything left, then flush with a held output pending
        iValid_BD = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step();
        iValid_BD = 1'b0;
        step();
        iValid_AF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iData_AF = {7'sd2, 7'sd2, 7'sd2, 7'sd2};
            step();
        end
        iValid_AF = 1'b0;
        iReady_AD = 1'b0; iValid_BD = 1'b1; iData_BD = 16'h1357;
        step();
        chk("fl_pre_count", 64'(oCount),    64'd2);
        chk("fl_pre_valid", 64'(oValid_AD), 64'd1);
        iFlush = 1'b1; iValid_AF = 1'b1; iValid_BD = 1'b1;
        #1;
        chk("fl_rdy_af", 64'(oReady_AF), 64'd0);
        chk("fl_rdy_bd", 64'(oReady_BD), 64'd0);
        step();
        iFlush = 1'b0; iValid_AF = 1'b0; iValid_BD = 1'b0;
        chk("fl_count", 64'(oCount),    64'd0);
        chk("fl_valid", 64'(oValid_AD), 64'd1);
        chk("fl_data",  64'(oData_AD),  64'h1357);
        iReady_AD = 1'b1;
        step();
        chk("fl_done", 64'(oValid_AD), 64'd0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/neuron_backprop.md
Name: neuron_backprop

Overview:
- Backward-pass partner of the forward ReLU neuron stage. It turns the back-propagated error for NC channels into error × ReLU'(v).
- It watches the forward pre-activation stream, v from the accumulator. From each forward sample it computes an NC-bit derivative mask and holds the masks in an in-order FIFO.
- Each backward error word takes the oldest mask and gates the error channel by channel.
- Output goes through one valid/ready pipeline register toward the previous layer's weight-update logic.

Parameters:
- NP, 4: fan-in of the forward neuron. Pre-activation channel width VW = $clog2(NP)+1+WD.
- NC, 4: channels per word.
- WD, 4: activation/error width, signed. MAX_YC = 2**(WD-1)-1.
- DEPTH, 4: mask FIFO entries. Must be a power of 2 and at least 2.

Ports:
- iCLK, in, 1: clock, rising edge.
- iRST, in, 1: reset, asynchronous, active-low.
- iValid_AF, in, 1: forward pre-activation valid.
- oReady_AF, out, 1: mask FIFO can accept a sample.
- iData_AF, in, NC*VW: signed pre-activations. Channel c is at [c*VW +: VW].
- iValid_BD, in, 1: backward error valid.
- oReady_BD, out, 1: backward error accepted this cycle.
- iData_BD, in, NC*WD: signed error. Channel c is at [c*WD +: WD].
- oValid_AD, out, 1: gated error valid.
- iReady_AD, in, 1: downstream ready.
- oData_AD, out, NC*WD: gated error.
- oCount, out, $clog2(DEPTH)+1: masks currently stored.

Behaviour:
- Reset (iRST=0, asynchronous): pointers=0, oCount=0, oValid_AD=0, oData_AD=0. oReady_AF=1 once reset is released.
- Mask rule, per channel: m[c] = (v>0) && (v<=MAX_YC), signed compare at VW bits.
  - v=0 gives 0.
  - Negative v gives 0.
  - Saturated v (above MAX_YC) gives 0.
- Push:
  - oReady_AF = (oCount<DEPTH).
  - When iValid_AF && oReady_AF, write the mask at wptr and increment wptr, wrapping modulo DEPTH.
  - No push-when-full even if a pop happens in the same cycle; oReady_AF depends only on registered oCount.
- Output register: w_rdy = !oValid_AD || iReady_AD.
- Pop/accept:
  - oReady_BD = (oCount!=0) && w_rdy.
  - On iValid_BD && oReady_BD:
    - oData_AD[c] <= m[c] ? err[c] : 0, where m is the entry at rptr. This includes err = -2**(WD-1), which passes unchanged.
    - rptr increments, wrapping.
    - oValid_AD <= 1.
- Output idle: if oValid_AD && iReady_AD with no accept, oValid_AD <= 0 and oData_AD holds.
- Stall: oData_AD and oValid_AD hold while oValid_AD && !iReady_AD.
- Latency: 1 cycle from backward accept to oValid_AD. A mask pushed in cycle t is usable for a pop at t+1 at the earliest; there is no empty-bypass.
- oCount:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Ordering: masks are consumed strictly in forward order. The block does not check sample identity.
- Throughput: one push and one pop per cycle sustained when 0<oCount<DEPTH.
- Error channel WD bits are passed through as-is; there is no rescaling.

Optional Feature:
- Macro: NEURON_BACKPROP_FLUSH_EN.
- Defined:
  - Adds input port iFlush (1 bit, synchronous, active-high).
  - In a cycle with iFlush=1, oReady_AF=0 and oReady_BD=0. Next edge: wptr=rptr=0, oCount=0.
  - The output register is untouched, so a pending oValid_AD still completes normally.
  - Flush takes priority over push and pop in the same cycle.
- Undefined: no port exists. The FIFO clears only via iRST.

Test Plan:
- Reset mid-stream: assert iRST=0 asynchronously with oCount=3 and oValid_AD=1. Required: outputs clear immediately, without waiting for a clock edge; oCount=0; oValid_AD=0.
- Mask derivation (NP=4, WD=4, VW=7):
  - Stimulus: push v=[-3,0,5,9] (ch3..ch0 = 9,5,0,-3), then error [2,-1,3,-8].
  - Required: one cycle after the accept, oData_AD = [0,0,3,0].
  - 5 passes; 9 is saturated; 0 and -3 are blocked.
- Full boundary (DEPTH=4):
  - Push 4 samples with iValid_BD=0. Required: oReady_AF=0, oCount=4.
  - Then pop and push together. Required: the pop is accepted, the push is held, oCount=3, and the push is accepted the next cycle.
- Empty boundary: hold iValid_BD=1 with oCount=0. Required: oReady_BD=0 and oValid_AD stays 0 until 1 cycle after the first push.
- Backpressure: hold iReady_AD=0 for 5 cycles while oValid_AD=1. Required: oData_AD is stable, oReady_BD=0, and oCount is unchanged; on release, back-to-back pops run at 1 per cycle.
- Flush (with the macro defined): with oCount=2 and oValid_AD=1, pulse iFlush together with iValid_AF=1. Required: the push is dropped, oCount=0 next cycle, and the held output is still delivered.
